cpu_2: RTL and testbench
========================

# cpu_2

Parametrised second-generation multi-cycle accumulator CPU. Generalises word and address width and adds ALU arithmetic/logic ops, zero/carry flags, conditional branches and a halt state. Runs a fixed 5-state fetch/execute sequence. An optional boot phase lets an external loader fill memory over the shared bus before execution starts at address 0. Sits at top level between the unified memory and the boot loader, exactly where the first-generation core sits.

## Interface
- WORD_SIZE, 16: data/instruction width; must satisfy WORD_SIZE >= ADDR_SIZE + 8 and be a multiple of 8
- ADDR_SIZE, 8: byte address width
- PC_STEP, WORD_SIZE/8: address increment per word
- clk  input  1  clock, all logic on posedge
- rst  input  1  synchronous, active-high reset
- data_bus  inout  WORD_SIZE  memory data; CPU drives only when wr_en && !boot, else 'bz
- addr_bus  output  ADDR_SIZE  memory address
- wr_en  output  1  memory write strobe
- boot  output  1  high during boot phase
- halted  output  1  high once HLT executed
- flags  output  2  {C, Z}

## Operation
- Instruction fields:
  - opcode = inst[WORD_SIZE-1 -: 5]
  - sel = inst[WORD_SIZE-6]: 0 = a, 1 = b
  - mode = inst[WORD_SIZE-7 -: 2]: 0 imm, 1 direct, 2 indirect, 3 treated as imm
  - operand = inst[ADDR_SIZE-1:0]
- Opcodes:
  - 0 NOP
  - 1 LOAD: reg[sel] <= src
  - 2 STO: mem[ea] <= reg[sel]
  - 3 MOV: reg[sel] <= reg[!sel]
  - 4 ADD: reg[sel] <= a + src
  - 5 SUB: reg[sel] <= a - src
  - 6 AND, 7 OR, 8 XOR: reg[sel] <= a op src
  - 9 JMP, 10 JZ (if Z), 11 JC (if C): pc <= operand
  - 31 HLT
  - all others execute as NOP
- src is the operand zero-extended for imm, else mem[ea]. ea is the operand for direct, or mem[operand][ADDR_SIZE-1:0] for indirect.
- Flags: ADD/SUB/logic update Z (result == 0). ADD sets C = carry-out; SUB sets C = borrow (a < src unsigned); logic ops clear C. LOAD/MOV/STO/jumps leave flags unchanged.
- Execute states:
  - S0 FETCH: addr_bus = pc; inst_reg <= data_bus.
  - S1 DECODE: addr_reg <= operand.
  - S2 ADDR: addr_bus = addr_reg; if indirect, addr_reg <= data_bus[ADDR_SIZE-1:0].
  - S3 MEM: addr_bus = addr_reg; read src, or for STO drive data_bus = reg[sel] with wr_en = 1 for exactly this cycle.
  - S4 WB: register and flag write. pc <= operand if a jump is taken, else pc + PC_STEP (wraps modulo 2^ADDR_SIZE). Next state is S0.
- HALT: entered from S4 of HLT. No bus activity; addr_bus holds pc, wr_en = 0, halted = 1. Left only by rst.
- MOV with sel = 0 copies b→a; with sel = 1 copies a→b.

## Timing
- Every instruction takes exactly 5 cycles; memory read data is combinational (valid in the same cycle as addr_bus).
- Reset values: pc = 0, addr_reg = 0, a = b = 0, flags = 0, halted = 0, wr_en = 0, addr_bus = 0. boot = 1 with the boot macro, 0 without.
- rst asserted in any state, including mid-STO, boot or HALT: all of the above reset on the next edge. An in-flight STO write is dropped if rst coincides with S3.
- Boot: addr_bus steps 0, PC_STEP, … up to 2^ADDR_SIZE − PC_STEP, one address per cycle, with wr_en = 1 and data_bus undriven by the CPU.
  - The cycle after the last address: boot = 0, wr_en = 0, state = S0, pc = 0.
  - Total duration is 2^ADDR_SIZE / PC_STEP cycles (128 at defaults).
- A jump taken to the current pc (self-loop) is legal and repeats every 5 cycles.

## Configuration
- CPU2_BOOT_EN defined: boot phase runs after every reset as specified above.
- CPU2_BOOT_EN undefined: boot output is tied to 0, no boot counter is built, and execution begins in S0 at pc = 0 on the first cycle after rst deasserts.

## Test plan
- Boot (macro on, defaults): release rst → boot high for 128 cycles, addr_bus 0..254 step 2 with wr_en = 1; then boot = 0 and first fetch at addr 0.
- Immediate/arith: LOAD a #5; LOAD b #3; ADD a, direct b-location holding 0xFFFB → a = 0x0000, Z = 1, C = 1, at S4 of cycle 15.
- Indirect + store: mem[0x40] = 0x50, mem[0x50] = 0x1234; LOAD b indirect 0x40; STO b direct 0x60 → wr_en exactly one cycle with addr_bus = 0x60, data_bus = 0x1234.
- Branch: SUB a − a sets Z = 1; JZ 0x20 → next fetch at 0x20. Repeat with Z = 0 → fetch at pc + 2.
- Halt and reset: HLT → halted = 1 and addr_bus frozen for 100 cycles; pulse rst during the HLT's S2 → all outputs at reset values next edge.
- Parametric: WORD_SIZE = 32, ADDR_SIZE = 10, macro off → pc steps by 4, JMP 0x3FC then wrap to 0x000 after the next sequential instruction.

Source files
------------

// File: rtl/cpu_2.sv
`default_nettype none
// ============================================================================
// Module   : cpu_2
// Purpose  : Parametrised multi-cycle accumulator CPU (5-state fetch/execute,
//            ALU flags, conditional branches, halt). Define CPU2_BOOT_EN to
//            add a boot phase in which an external loader fills memory.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_2 #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 8,
  parameter int PC_STEP   = WORD_SIZE / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  inout  wire  [WORD_SIZE-1:0] data_bus,
  output logic [ADDR_SIZE-1:0] addr_bus,
  output logic                 wr_en,
  output logic                 boot,
  output logic                 halted,
  output logic [1:0]           flags
);

  localparam logic [2:0] c_s_fetch  = 3'd0;
  localparam logic [2:0] c_s_decode = 3'd1;
  localparam logic [2:0] c_s_addr   = 3'd2;
  localparam logic [2:0] c_s_mem    = 3'd3;
  localparam logic [2:0] c_s_wb     = 3'd4;
  localparam logic [2:0] c_s_halt   = 3'd5;
`ifdef CPU2_BOOT_EN
  localparam logic [2:0] c_s_boot   = 3'd6;
`endif

  localparam logic [4:0] c_op_load = 5'd1;
  localparam logic [4:0] c_op_sto  = 5'd2;
  localparam logic [4:0] c_op_mov  = 5'd3;
  localparam logic [4:0] c_op_add  = 5'd4;
  localparam logic [4:0] c_op_sub  = 5'd5;
  localparam logic [4:0] c_op_and  = 5'd6;
  localparam logic [4:0] c_op_or   = 5'd7;
  localparam logic [4:0] c_op_xor  = 5'd8;
  localparam logic [4:0] c_op_jmp  = 5'd9;
  localparam logic [4:0] c_op_jz   = 5'd10;
  localparam logic [4:0] c_op_jc   = 5'd11;
  localparam logic [4:0] c_op_hlt  = 5'd31;

  localparam logic [1:0] c_mode_direct   = 2'd1;
  localparam logic [1:0] c_mode_indirect = 2'd2;

  localparam logic [ADDR_SIZE-1:0] c_pc_step = ADDR_SIZE'(PC_STEP);

  logic [2:0]           r_state;
  logic [ADDR_SIZE-1:0] r_pc;
  logic [ADDR_SIZE-1:0] r_addr;
  logic [WORD_SIZE-1:0] r_inst;
  logic [WORD_SIZE-1:0] r_a;
  logic [WORD_SIZE-1:0] r_b;
  logic [WORD_SIZE-1:0] r_src;
  logic                 r_c;
  logic                 r_z;
  logic                 r_halted;

  logic [4:0]           w_opcode;
  logic                 w_sel;
  logic [1:0]           w_mode;
  logic [ADDR_SIZE-1:0] w_operand;
  logic [WORD_SIZE-1:0] w_operand_ext;
  logic                 w_mem_src;
  logic                 w_store;
  logic [WORD_SIZE-1:0] w_store_data;
  logic [WORD_SIZE:0]   w_sum;
  logic [WORD_SIZE:0]   w_diff;
  logic [WORD_SIZE-1:0] w_result;
  logic                 w_wr_reg;
  logic                 w_flag_upd;
  logic                 w_c_next;
  logic                 w_jump;

  assign w_opcode      = r_inst[WORD_SIZE-1 -: 5];
  assign w_sel         = r_inst[WORD_SIZE-6];
  assign w_mode        = r_inst[WORD_SIZE-7 -: 2];
  assign w_operand     = r_inst[ADDR_SIZE-1:0];
  assign w_operand_ext = {{(WORD_SIZE-ADDR_SIZE){1'b0}}, w_operand};
  assign w_mem_src     = (w_mode == c_mode_direct) || (w_mode == c_mode_indirect);

  // Gating with rst drops a store that would otherwise land on the reset edge.
  assign w_store       = (r_state == c_s_mem) && (w_opcode == c_op_sto) && !rst;
  assign w_store_data  = w_sel ? r_b : r_a;
  assign data_bus      = w_store ? w_store_data : {WORD_SIZE{1'bz}};

  assign w_sum  = {1'b0, r_a} + {1'b0, r_src};
  assign w_diff = {1'b0, r_a} - {1'b0, r_src};

  assign halted = r_halted;
  assign flags  = {r_c, r_z};

`ifdef CPU2_BOOT_EN
  localparam logic [ADDR_SIZE-1:0] c_boot_last = '0 - c_pc_step;

  logic [ADDR_SIZE-1:0] r_boot_cnt;

  assign boot  = (r_state == c_s_boot);
  assign wr_en = !rst && (w_store || (r_state == c_s_boot));
`else
  assign boot  = 1'b0;
  assign wr_en = w_store;
`endif

  always_comb begin
    addr_bus = r_pc;
    case (r_state)
      c_s_addr, c_s_mem: addr_bus = r_addr;
`ifdef CPU2_BOOT_EN
      c_s_boot:          addr_bus = r_boot_cnt;
`endif
      default:           addr_bus = r_pc;
    endcase
  end

  always_comb begin
    w_result   = r_src;
    w_wr_reg   = 1'b0;
    w_flag_upd = 1'b0;
    w_c_next   = r_c;
    w_jump     = 1'b0;
    case (w_opcode)
      c_op_load: begin
        w_result = r_src;
        w_wr_reg = 1'b1;
      end
      c_op_mov: begin
        w_result = w_sel ? r_a : r_b;
        w_wr_reg = 1'b1;
      end
      c_op_add: begin
        w_result   = w_sum[WORD_SIZE-1:0];
        w_c_next   = w_sum[WORD_SIZE];
        w_wr_reg   = 1'b1;
        w_flag_upd = 1'b1;
      end
      // The extra top bit of the difference is exactly the unsigned borrow.
      c_op_sub: begin
        w_result   = w_diff[WORD_SIZE-1:0];
        w_c_next   = w_diff[WORD_SIZE];
        w_wr_reg   = 1'b1;
        w_flag_upd = 1'b1;
      end
      c_op_and: begin
        w_result   = r_a & r_src;
        w_c_next   = 1'b0;
        w_wr_reg   = 1'b1;
        w_flag_upd = 1'b1;
      end
      c_op_or: begin
        w_result   = r_a | r_src;
        w_c_next   = 1'b0;
        w_wr_reg   = 1'b1;
        w_flag_upd = 1'b1;
      end
      c_op_xor: begin
        w_result   = r_a ^ r_src;
        w_c_next   = 1'b0;
        w_wr_reg   = 1'b1;
        w_flag_upd = 1'b1;
      end
      c_op_jmp: w_jump = 1'b1;
      c_op_jz:  w_jump = r_z;
      c_op_jc:  w_jump = r_c;
      default:  w_jump = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef CPU2_BOOT_EN
      r_state    <= c_s_boot;
      r_boot_cnt <= '0;
`else
      r_state    <= c_s_fetch;
`endif
      r_pc     <= '0;
      r_addr   <= '0;
      r_inst   <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_src    <= '0;
      r_c      <= 1'b0;
      r_z      <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        c_s_fetch: begin
          r_inst  <= data_bus;
          r_state <= c_s_decode;
        end
        c_s_decode: begin
          r_addr  <= w_operand;
          r_state <= c_s_addr;
        end
        c_s_addr: begin
          if (w_mode == c_mode_indirect) begin
            r_addr <= data_bus[ADDR_SIZE-1:0];
          end
          r_state <= c_s_mem;
        end
        c_s_mem: begin
          r_src   <= w_mem_src ? data_bus : w_operand_ext;
          r_state <= c_s_wb;
        end
        c_s_wb: begin
          if (w_wr_reg) begin
            if (w_sel) begin
              r_b <= w_result;
            end else begin
              r_a <= w_result;
            end
          end
          if (w_flag_upd) begin
            r_z <= (w_result == '0);
            r_c <= w_c_next;
          end
          r_pc <= w_jump ? w_operand : r_pc + c_pc_step;
          if (w_opcode == c_op_hlt) begin
            r_halted <= 1'b1;
            r_state  <= c_s_halt;
          end else begin
            r_state  <= c_s_fetch;
          end
        end
        c_s_halt: r_state <= c_s_halt;
`ifdef CPU2_BOOT_EN
        c_s_boot: begin
          if (r_boot_cnt == c_boot_last) begin
            r_state <= c_s_fetch;
          end else begin
            r_boot_cnt <= r_boot_cnt + c_pc_step;
          end
        end
`endif
        default: r_state <= c_s_fetch;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_2.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_2
// Purpose  : Self-checking bench for cpu_2: ALU vector table, directed corner
//            sequences, random programs against an instruction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  wire  [15:0] data_bus;
  logic [7:0]  addr_bus;
  logic        wr_en, boot, halted;
  logic [1:0]  flags;

  logic        rst2 = 1'b1;
  wire  [31:0] data_bus2;
  logic [9:0]  addr2;
  logic        wr2, boot2, halted2;
  logic [1:0]  flags2;

  always #5 clk = ~clk;

  cpu_2 #(.WORD_SIZE(16), .ADDR_SIZE(8), .PC_STEP(2)) dut (
    .clk(clk), .rst(rst), .data_bus(data_bus), .addr_bus(addr_bus),
    .wr_en(wr_en), .boot(boot), .halted(halted), .flags(flags));

  cpu_2 #(.WORD_SIZE(32), .ADDR_SIZE(10), .PC_STEP(4)) dut2 (
    .clk(clk), .rst(rst2), .data_bus(data_bus2), .addr_bus(addr2),
    .wr_en(wr2), .boot(boot2), .halted(halted2), .flags(flags2));

  // Word-organised memories; the loader re-supplies current contents during boot.
  logic [15:0] mem  [0:127];
  logic [31:0] mem2 [0:255];
  assign data_bus  = (wr_en && !boot) ? 16'bz : mem[addr_bus[7:1]];
  assign data_bus2 = (wr2 && !boot2) ? 32'bz : mem2[addr2[9:2]];
  always @(posedge clk) if (wr_en) mem[addr_bus[7:1]] <= data_bus;
  always @(posedge clk) if (wr2) mem2[addr2[9:2]] <= data_bus2;

  int errors = 0;
  int checks = 0;

  // Instruction-level reference model
  logic [15:0] mm [0:127];
  logic [15:0] ma, mb;
  logic        mc, mz, mh;
  logic [7:0]  mpc;

  int          last_wc;
  logic [7:0]  last_wa;
  logic [15:0] last_wd;

  typedef struct {
    logic [4:0]  op;
    logic [15:0] a_val;
    logic [15:0] src;
    logic [15:0] exp_res;
    logic [1:0]  exp_flags;
  } alu_vec_t;
  alu_vec_t vecs [0:10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic [4:0] op, input logic sel,
                                      input logic [1:0] mode, input logic [7:0] opd);
    return {op, sel, mode, opd};
  endfunction

  function automatic logic [15:0] rand_inst();
    int r;
    logic [4:0] op;
    r = $urandom_range(0, 31);
    if (r < 24)      op = 5'(r % 12);
    else if (r < 30) op = 5'(12 + $urandom_range(0, 18));
    else             op = 5'd31;
    return {op, 1'($urandom), 2'($urandom), 8'($urandom)};
  endfunction

  task automatic set_word(input int idx, input logic [15:0] v);
    mem[idx] <= v;
    mm[idx] = v;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 128; i++) set_word(i, 16'h0000);
  endtask

  task automatic model_step(output int ewr, output logic [7:0] ewa, output logic [15:0] ewd);
    logic [15:0] inst, src, res;
    logic [4:0]  op;
    logic        sel, take, wreg, fl;
    logic [1:0]  mode;
    logic [7:0]  opd, ea;
    int          s;
    ewr = 0; ewa = '0; ewd = '0;
    if (mh) return;
    inst = mm[mpc[7:1]];
    op = inst[15:11]; sel = inst[10]; mode = inst[9:8]; opd = inst[7:0];
    ea  = (mode == 2'd2) ? mm[opd[7:1]][7:0] : opd;
    src = (mode == 2'd1 || mode == 2'd2) ? mm[ea[7:1]] : {8'h00, opd};
    take = 0; wreg = 0; fl = 0; res = '0;
    case (op)
      5'd1: begin res = src; wreg = 1; end
      5'd2: begin ewr = 1; ewa = ea; ewd = sel ? mb : ma; mm[ea[7:1]] = ewd; end
      5'd3: begin res = sel ? ma : mb; wreg = 1; end
      5'd4: begin s = int'(ma) + int'(src); res = 16'(s); mc = (s > 65535); wreg = 1; fl = 1; end
      5'd5: begin res = ma - src; mc = (ma < src); wreg = 1; fl = 1; end
      5'd6: begin res = ma & src; mc = 0; wreg = 1; fl = 1; end
      5'd7: begin res = ma | src; mc = 0; wreg = 1; fl = 1; end
      5'd8: begin res = ma ^ src; mc = 0; wreg = 1; fl = 1; end
      5'd9:  take = 1;
      5'd10: take = mz;
      5'd11: take = mc;
      5'd31: mh = 1;
      default: ;
    endcase
    if (fl) mz = (res == 16'h0000);
    if (wreg) begin
      if (sel) mb = res; else ma = res;
    end
    mpc = take ? opd : mpc + 8'd2;
  endtask

  task automatic do_reset();
    int bad;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
`ifdef CPU2_BOOT_EN
    bad = 0;
    for (int i = 0; i < 128; i++) begin
      if (boot !== 1'b1 || wr_en !== 1'b1 || addr_bus !== 8'(2 * i)) bad++;
      @(posedge clk); #1;
    end
    chk("boot_seq", 32'(bad), 32'd0);
`endif
    chk("rst_addr",   32'(addr_bus), 32'd0);
    chk("rst_wr_en",  32'(wr_en),    32'd0);
    chk("rst_halted", 32'(halted),   32'd0);
    chk("rst_flags",  32'(flags),    32'd0);
    chk("rst_boot",   32'(boot),     32'd0);
  endtask

  task automatic start();
    ma = '0; mb = '0; mc = 0; mz = 0; mh = 0; mpc = '0;
    do_reset();
  endtask

  // Runs one 5-cycle instruction slot and compares against the model.
  task automatic step_check();
    int ewr;
    logic [7:0]  ewa;
    logic [15:0] ewd;
    last_wc = 0; last_wa = '0; last_wd = '0;
    for (int i = 0; i < 5; i++) begin
      if (wr_en) begin
        last_wc++; last_wa = addr_bus; last_wd = data_bus;
      end
      @(posedge clk); #1;
    end
    model_step(ewr, ewa, ewd);
    chk("wr_count", 32'(last_wc), 32'(ewr));
    if (ewr != 0) begin
      chk("wr_addr", 32'(last_wa), 32'(ewa));
      chk("wr_data", 32'(last_wd), 32'(ewd));
    end
    chk("pc",     32'(addr_bus), 32'(mpc));
    chk("flags",  32'(flags),    32'({mc, mz}));
    chk("halted", 32'(halted),   32'(mh));
  endtask

  initial begin
    int bad;
    vecs[0]  = '{5'd4, 16'h0005, 16'hFFFB, 16'h0000, 2'b11};
    vecs[1]  = '{5'd4, 16'h1234, 16'h1111, 16'h2345, 2'b00};
    vecs[2]  = '{5'd4, 16'h8000, 16'h8000, 16'h0000, 2'b11};
    vecs[3]  = '{5'd5, 16'h0005, 16'h0005, 16'h0000, 2'b01};
    vecs[4]  = '{5'd5, 16'h0003, 16'h0005, 16'hFFFE, 2'b10};
    vecs[5]  = '{5'd5, 16'hFFFF, 16'h0001, 16'hFFFE, 2'b00};
    vecs[6]  = '{5'd6, 16'hF0F0, 16'h0FF0, 16'h00F0, 2'b00};
    vecs[7]  = '{5'd6, 16'hAAAA, 16'h5555, 16'h0000, 2'b01};
    vecs[8]  = '{5'd7, 16'h00FF, 16'hFF00, 16'hFFFF, 2'b00};
    vecs[9]  = '{5'd8, 16'h1234, 16'h1234, 16'h0000, 2'b01};
    vecs[10] = '{5'd8, 16'hFFFF, 16'h0F0F, 16'hF0F0, 2'b00};
    for (int i = 0; i < 256; i++) mem2[i] <= 32'h0;
    mem2[1] <= {5'd9, 1'b0, 2'd0, 14'd0, 10'h3FC};

    // ALU table; the leading SUB b #1 leaves C set so logic ops must clear it.
    for (int v = 0; v <= 10; v++) begin
      clear_mem();
      set_word(0, enc(5'd5, 1'b1, 2'd0, 8'h01));
      set_word(1, enc(5'd1, 1'b0, 2'd1, 8'h70));
      set_word(2, enc(vecs[v].op, 1'b0, 2'd1, 8'h72));
      set_word(3, enc(5'd2, 1'b0, 2'd1, 8'h74));
      set_word(4, enc(5'd31, 1'b0, 2'd0, 8'h00));
      set_word(8'h38, vecs[v].a_val);
      set_word(8'h39, vecs[v].src);
      start();
      repeat (5) step_check();
      chk($sformatf("alu%0d_res", v),   32'(mem[8'h3A]), 32'(vecs[v].exp_res));
      chk($sformatf("alu%0d_flags", v), 32'(flags),      32'(vecs[v].exp_flags));
    end

    // Immediate loads then ADD overflow to zero
    clear_mem();
    set_word(0, enc(5'd1, 1'b0, 2'd0, 8'h05));
    set_word(1, enc(5'd1, 1'b1, 2'd0, 8'h03));
    set_word(2, enc(5'd4, 1'b0, 2'd1, 8'h70));
    set_word(3, enc(5'd2, 1'b0, 2'd1, 8'h72));
    set_word(4, enc(5'd2, 1'b1, 2'd1, 8'h74));
    set_word(5, enc(5'd31, 1'b0, 2'd0, 8'h00));
    set_word(8'h38, 16'hFFFB);
    start();
    repeat (3) step_check();
    chk("arith_flags", 32'(flags), 32'h3);
    repeat (3) step_check();
    chk("arith_a", 32'(mem[8'h39]), 32'h0000);
    chk("arith_b", 32'(mem[8'h3A]), 32'h0003);

    // Indirect load then single-cycle store
    clear_mem();
    set_word(0, enc(5'd1, 1'b1, 2'd2, 8'h40));
    set_word(1, enc(5'd2, 1'b1, 2'd1, 8'h60));
    set_word(2, enc(5'd31, 1'b0, 2'd0, 8'h00));
    set_word(8'h20, 16'h0050);
    set_word(8'h28, 16'h1234);
    start();
    step_check();
    step_check();
    chk("sto_pulses", 32'(last_wc), 32'd1);
    chk("sto_addr",   32'(last_wa), 32'h60);
    chk("sto_data",   32'(last_wd), 32'h1234);
    chk("sto_mem",    32'(mem[8'h30]), 32'h1234);

    // JZ taken after SUB a - a
    clear_mem();
    set_word(0, enc(5'd1, 1'b0, 2'd0, 8'h07));
    set_word(1, enc(5'd2, 1'b0, 2'd1, 8'h70));
    set_word(2, enc(5'd5, 1'b0, 2'd1, 8'h70));
    set_word(3, enc(5'd10, 1'b0, 2'd0, 8'h20));
    set_word(8'h10, enc(5'd31, 1'b0, 2'd0, 8'h00));
    start();
    repeat (4) step_check();
    chk("jz_taken_pc", 32'(addr_bus), 32'h20);
    chk("jz_taken_z",  32'(flags),    32'h1);

    // JZ not taken
    clear_mem();
    set_word(0, enc(5'd1, 1'b0, 2'd0, 8'h07));
    set_word(1, enc(5'd5, 1'b0, 2'd0, 8'h01));
    set_word(2, enc(5'd10, 1'b0, 2'd0, 8'h20));
    set_word(3, enc(5'd31, 1'b0, 2'd0, 8'h00));
    start();
    repeat (3) step_check();
    chk("jz_not_taken_pc", 32'(addr_bus), 32'h06);

    // Self-loop
    clear_mem();
    set_word(0, enc(5'd9, 1'b0, 2'd0, 8'h00));
    start();
    repeat (3) step_check();
    chk("self_loop_pc", 32'(addr_bus), 32'h00);

    // Halt freezes the bus
    clear_mem();
    set_word(0, enc(5'd5, 1'b0, 2'd0, 8'h01));
    set_word(1, enc(5'd31, 1'b0, 2'd0, 8'h00));
    start();
    repeat (2) step_check();
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_pc",   32'(addr_bus), 32'h04);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (addr_bus !== 8'h04 || wr_en !== 1'b0 || halted !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    chk("halt_frozen", 32'(bad), 32'd0);

    // Reset during the HLT's S2
    start();
    step_check();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_flags", 32'(flags), 32'h2);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("hlt_rst_addr",   32'(addr_bus), 32'd0);
    chk("hlt_rst_wr",     32'(wr_en),    32'd0);
    chk("hlt_rst_halted", 32'(halted),   32'd0);
    chk("hlt_rst_flags",  32'(flags),    32'd0);
`ifdef CPU2_BOOT_EN
    chk("hlt_rst_boot",   32'(boot),     32'd1);
`else
    chk("hlt_rst_boot",   32'(boot),     32'd0);
`endif

    // Reset coinciding with the STO write cycle drops the write
    clear_mem();
    set_word(0, enc(5'd1, 1'b0, 2'd0, 8'h55));
    set_word(1, enc(5'd2, 1'b0, 2'd1, 8'h70));
    set_word(8'h38, 16'hBEEF);
    start();
    step_check();
    repeat (3) begin @(posedge clk); #1; end
    chk("sto_strobe", 32'(wr_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("sto_rst_gate", 32'(wr_en), 32'd0);
    @(posedge clk); #1;
    chk("sto_dropped", 32'(mem[8'h38]), 32'hBEEF);

    // Random programs against the model
    for (int p = 0; p < 10; p++) begin
      for (int i = 0; i < 128; i++) set_word(i, rand_inst());
      start();
      repeat (40) step_check();
      bad = 0;
      for (int i = 0; i < 128; i++) if (mem[i] !== mm[i]) bad++;
      chk($sformatf("rand%0d_mem", p), 32'(bad), 32'd0);
    end
    rst = 1'b1;

    // 32-bit word / 10-bit address build: step of 4 and wrap after 0x3FC
    rst2 = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst2 = 1'b0;
`ifdef CPU2_BOOT_EN
    bad = 0;
    while (boot2 === 1'b1 && bad < 300) begin
      @(posedge clk); #1;
      bad++;
    end
    chk("p32_boot_len", 32'(bad), 32'd256);
`endif
    chk("p32_start",  32'(addr2), 32'h000);
    chk("p32_halted", 32'(halted2), 32'd0);
    repeat (5) begin @(posedge clk); #1; end
    chk("p32_step", 32'(addr2), 32'h004);
    repeat (5) begin @(posedge clk); #1; end
    chk("p32_jmp", 32'(addr2), 32'h3FC);
    repeat (5) begin @(posedge clk); #1; end
    chk("p32_wrap", 32'(addr2), 32'h000);
    chk("p32_flags", 32'(flags2), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
